pulse_peak_detector: RTL
========================

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 SHALL have parameter DATA_W, default SIZE_FILTER_DATA, the width of the filtered sample, signed two's complement.
REQ-002 SHALL have parameter TS_W, default 32, the timestamp width.
REQ-003 SHALL have parameter WIDTH_W, default 12, the pulse-width field width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: detection enable.
REQ-007 SHALL have port input_data, input, DATA_W bits: filter output sample, one per clock.
REQ-008 SHALL have port threshold, input, DATA_W bits: signed trigger level.
REQ-009 SHALL have port holdoff, input, 8 bits: re-arm dead time, in clocks.
REQ-010 SHALL have port event_valid, output, 1 bit: an event is pending.
REQ-011 SHALL have port event_ready, input, 1 bit: the consumer accepts the event.
REQ-012 SHALL have port event_amp, output, DATA_W bits: peak amplitude.
REQ-013 SHALL have port event_time, output, TS_W bits: timestamp of the peak sample.
REQ-014 SHALL have port event_width, output, WIDTH_W bits: count of above-threshold samples.
REQ-015 SHALL have port event_flags, output, 2 bits: bit0 = width saturated, bit1 = an earlier event was lost.
REQ-016 SHALL have port lost_count, output, 8 bits: number of dropped events, saturating.

Function
REQ-017 SHALL register input_data into x_r each clock, and register the free-running counter ts (reset 0, +1 per clock, wraps at 2^TS_W) into ts_r alongside it.
REQ-018 SHALL make all comparisons on x_r as signed values; "above" means x_r > threshold, strictly.
REQ-019 SHALL use FSM states IDLE, PULSE and HOLDOFF.
REQ-020 In IDLE, when x_r is above threshold, SHALL go to PULSE and load peak=x_r, ptime=ts_r, width=1.
REQ-021 In PULSE, when x_r is above threshold, SHALL increment width, saturating at 2^WIDTH_W-1 and setting the sat flag, and SHALL update peak/ptime only if x_r > peak; on ties the first maximum is kept.
REQ-022 In PULSE, when x_r <= threshold, the pulse SHALL end: the event is emitted per REQ-025 to REQ-027, and the FSM goes to IDLE if holdoff==0, else to HOLDOFF with cnt=holdoff.
REQ-023 In HOLDOFF, samples SHALL be ignored and cnt decremented each clock; the FSM returns to IDLE on the clock where cnt==1.
REQ-024 With enable low, the FSM SHALL be forced to IDLE and any in-progress pulse discarded without an event; ts, x_r and the output register are unaffected.
REQ-025 event_valid SHALL assert 2 clocks after the edge that samples the first sub-threshold input_data.
REQ-026 event_valid and all event fields SHALL remain stable until a clock edge with event_valid && event_ready.
REQ-027 Event completion SHALL be handled as follows:
- completion with event_valid=0, or with event_valid && event_ready: the output is loaded with the new event and event_valid=1;
- completion with event_valid && !event_ready: the new event is dropped, lost_count increments (saturating at 255), and a lost flag is latched;
- that lost flag is reported in event_flags bit1 of the next loaded event, then cleared.
REQ-028 A handshake with no simultaneous completion SHALL clear event_valid on that edge.
REQ-029 Block throughput SHALL be a pulse end every 2 clocks at minimum (pulse width 1, holdoff 0), with no internal stall.

Reset
REQ-030 On reset assertion, asynchronously: FSM=IDLE; ts, x_r, ts_r, peak, width, cnt = 0; event_valid=0; event_amp/time/width/flags=0; lost_count=0; lost flag cleared.
REQ-031 A reset mid-pulse or mid-HOLDOFF SHALL discard the pulse; the first sample captured after reset release gets ts_r=0.

Verification
REQ-032 threshold=100, holdoff=0, input 0,50,150,300,250,80, event_ready=1 -> one event: amp=300, width=3, time=ts_r of the 300 sample, flags=0; valid 2 clocks after the 80 is sampled.
REQ-033 Tie: input 0,200,200,150,0 with threshold=100 -> amp=200, time=ts_r of the first 200, width=3.
REQ-034 Backpressure: event_ready=0, two pulses -> first event held unchanged and second dropped, lost_count=1; then ready=1 and a third pulse -> third event has flags bit1=1, a following event has bit1=0.
REQ-035 Holdoff: holdoff=4, a second pulse starting 2 clocks after the first ends -> second ignored until cnt expires; an above-threshold sample after IDLE re-entry starts a new pulse.
REQ-036 Negative/saturation: threshold=-50, WIDTH_W=4, 20 samples of -10 then -60 -> width=15, flags bit0=1, amp=-10.
REQ-037 Reset asserted mid-PULSE, or enable dropped mid-PULSE -> no event emitted, outputs at reset values (reset case only), lost_count unchanged by the enable case.

Source files
------------

// File: rtl/pulse_peak_detector.sv
// Pulse peak detector: finds above-threshold pulses in a filtered sample stream and
// reports peak amplitude, peak timestamp and pulse width through a valid/ready event port.
`ifndef SIZE_FILTER_DATA
`define SIZE_FILTER_DATA 16
`endif

module pulse_peak_detector #(
    parameter int DATA_W  = `SIZE_FILTER_DATA,
    parameter int TS_W    = 32,
    parameter int WIDTH_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DATA_W-1:0]  input_data,
    input  logic [DATA_W-1:0]  threshold,
    input  logic [7:0]         holdoff,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [DATA_W-1:0]  event_amp,
    output logic [TS_W-1:0]    event_time,
    output logic [WIDTH_W-1:0] event_width,
    output logic [1:0]         event_flags,
    output logic [7:0]         lost_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    state_t              state_r, state_s;
    logic [TS_W-1:0]     ts_cnt_r;
    logic [TS_W-1:0]     ts_r;
    logic [DATA_W-1:0]   x_r;
    logic [DATA_W-1:0]   peak_r, peak_s;
    logic [TS_W-1:0]     ptime_r, ptime_s;
    logic [WIDTH_W-1:0]  width_r, width_s;
    logic                sat_r, sat_s;
    logic [7:0]          cnt_r, cnt_s;
    logic                done_s;
    logic                above_s;
    logic                higher_s;

    logic                done_r;
    logic [DATA_W-1:0]   done_amp_r;
    logic [TS_W-1:0]     done_time_r;
    logic [WIDTH_W-1:0]  done_width_r;
    logic                done_sat_r;

    logic                event_valid_r;
    logic [DATA_W-1:0]   event_amp_r;
    logic [TS_W-1:0]     event_time_r;
    logic [WIDTH_W-1:0]  event_width_r;
    logic [1:0]          event_flags_r;
    logic [7:0]          lost_count_r;
    logic                lost_flag_r;

    assign above_s  = $signed(x_r) > $signed(threshold);
    assign higher_s = $signed(x_r) > $signed(peak_r);

    // Free-running timestamp and input sample register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_r <= '0;
            ts_r     <= '0;
            x_r      <= '0;
        end else begin
            ts_cnt_r <= ts_cnt_r + TS_W'(1);
            ts_r     <= ts_cnt_r;
            x_r      <= input_data;
        end
    end

    // Detection FSM state and pulse accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            peak_r  <= '0;
            ptime_r <= '0;
            width_r <= '0;
            sat_r   <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            peak_r  <= peak_s;
            ptime_r <= ptime_s;
            width_r <= width_s;
            sat_r   <= sat_s;
            cnt_r   <= cnt_s;
        end
    end

    // Detection FSM next state; a pulse ends on the first sample at or below threshold.
    always_comb begin
        state_s = state_r;
        peak_s  = peak_r;
        ptime_s = ptime_r;
        width_s = width_r;
        sat_s   = sat_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        if (!enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (above_s) begin
                        state_s = PULSE;
                        peak_s  = x_r;
                        ptime_s = ts_r;
                        width_s = WIDTH_W'(1);
                        sat_s   = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                PULSE: begin
                    if (above_s) begin
                        if (width_r == WIDTH_MAX) begin
                            sat_s = 1'b1;
                        end else begin
                            width_s = width_r + WIDTH_W'(1);
                        end
                        // Strict compare keeps the first of equal maxima.
                        if (higher_s) begin
                            peak_s  = x_r;
                            ptime_s = ts_r;
                        end else begin
                            peak_s  = peak_r;
                        end
                    end else begin
                        done_s = 1'b1;
                        if (holdoff == 8'd0) begin
                            state_s = IDLE;
                        end else begin
                            state_s = HOLDOFF;
                            cnt_s   = holdoff;
                        end
                    end
                end
                HOLDOFF: begin
                    if (cnt_r <= 8'd1) begin
                        state_s = IDLE;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Completion stage: captures the finished pulse one clock before the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r       <= 1'b0;
            done_amp_r   <= '0;
            done_time_r  <= '0;
            done_width_r <= '0;
            done_sat_r   <= 1'b0;
        end else begin
            done_r <= done_s;
            if (done_s) begin
                done_amp_r   <= peak_r;
                done_time_r  <= ptime_r;
                done_width_r <= width_r;
                done_sat_r   <= sat_r;
            end
        end
    end

    // Event output register with drop-on-backpressure and lost-event bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_valid_r <= 1'b0;
            event_amp_r   <= '0;
            event_time_r  <= '0;
            event_width_r <= '0;
            event_flags_r <= 2'b00;
            lost_count_r  <= 8'd0;
            lost_flag_r   <= 1'b0;
        end else begin
            if (done_r) begin
                if (!event_valid_r || event_ready) begin
                    event_valid_r <= 1'b1;
                    event_amp_r   <= done_amp_r;
                    event_time_r  <= done_time_r;
                    event_width_r <= done_width_r;
                    event_flags_r <= {lost_flag_r, done_sat_r};
                    lost_flag_r   <= 1'b0;
                end else begin
                    lost_flag_r <= 1'b1;
                    if (lost_count_r != 8'hFF) begin
                        lost_count_r <= lost_count_r + 8'd1;
                    end
                end
            end else if (event_valid_r && event_ready) begin
                event_valid_r <= 1'b0;
            end
        end
    end

    assign event_valid = event_valid_r;
    assign event_amp   = event_amp_r;
    assign event_time  = event_time_r;
    assign event_width = event_width_r;
    assign event_flags = event_flags_r;
    assign lost_count  = lost_count_r;

endmodule
